// File: rtl/src_pkg.sv
// src_pkg: shared widths, ALU opcodes and bus-source indices for the Mini-SRC datapath
//   DATA_W / NUM_REGS / NUM_SRC : fixed datapath geometry
//   ALU_*                       : 4-bit ALU operation codes
//   SRC_*                       : bit positions of the one-hot bus driver strobes
package src_pkg;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int NUM_SRC  = 9;
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_SHR = 4'h2;
   localparam logic [3:0] ALU_SHL = 4'h3;
   localparam logic [3:0] ALU_ROR = 4'h4;
   localparam logic [3:0] ALU_ROL = 4'h5;
   localparam logic [3:0] ALU_AND = 4'h6;
   localparam logic [3:0] ALU_OR  = 4'h7;
   localparam logic [3:0] ALU_MUL = 4'h8;
   localparam logic [3:0] ALU_DIV = 4'h9;
   localparam logic [3:0] ALU_NEG = 4'hA;
   localparam logic [3:0] ALU_NOT = 4'hB;
   localparam int SRC_REGFILE = 0;
   localparam int SRC_HI      = 1;
   localparam int SRC_LO      = 2;
   localparam int SRC_Z_HI    = 3;
   localparam int SRC_Z_LO    = 4;
   localparam int SRC_PC      = 5;
   localparam int SRC_MDR     = 6;
   localparam int SRC_INPORT  = 7;
   localparam int SRC_C       = 8;
endpackage

// File: rtl/src_alu_32.sv
// src_alu_32: combinational 32-bit ALU with 64-bit result (A = Y, B = bus)
//   opcode : ALU operation (ALU_* in src_pkg)
//   a, b   : operands
//   result : 64-bit result; upper half is 0 except for MUL and DIV
module src_alu_32
   import src_pkg::*;
(
   input  logic [3:0]          opcode,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic [2*DATA_W-1:0] result
);
   logic [4:0]          sh;
   logic [2*DATA_W-1:0] ror_w, rol_w, prod;
   logic [DATA_W-1:0]   quo, rem;
   assign sh = b[4:0];
   // rotating the doubled word lets a plain shift do the wrap-around
   assign ror_w = {a, a} >> sh;
   assign rol_w = {a, a} << sh;
   assign prod  = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
   assign quo   = (b == '0) ? '0 : $signed(a) / $signed(b);
   assign rem   = (b == '0) ? '0 : $signed(a) % $signed(b);
   always_comb begin
      result = '0;
      case (opcode)
         ALU_ADD: result = {32'h0, a + b};
         ALU_SUB: result = {32'h0, a - b};
         ALU_SHR: result = {32'h0, a >> sh};
         ALU_SHL: result = {32'h0, a << sh};
         ALU_ROR: result = {32'h0, ror_w[DATA_W-1:0]};
         ALU_ROL: result = {32'h0, rol_w[2*DATA_W-1:DATA_W]};
         ALU_AND: result = {32'h0, a & b};
         ALU_OR:  result = {32'h0, a | b};
         ALU_MUL: result = prod;
         ALU_DIV: result = {rem, quo};
         ALU_NEG: result = {32'h0, -b};
         ALU_NOT: result = {32'h0, ~b};
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/src_datapath_32.sv
// src_datapath_32: Mini-SRC single-bus datapath (regfile, PC, IR, Y, Z, MAR, HI, LO, MDR, ALU)
//   clk, in_reg_clear_n      : clock, asynchronous active-low clear of every register
//   in_regfile_location      : GPR index for both read and write
//   in_alu_opcode            : ALU operation feeding Z
//   in_mem_data/in_mdr_select: MDR source (memory when select = 1, else bus)
//   in_inc_pc                : PC source (PC+1 when 1, else bus)
//   in_*_read                : one-hot bus driver strobes
//   in_*_write               : register load enables
//   out_bus                  : current bus value
module src_datapath_32
   import src_pkg::*;
(
   input  logic              clk,
   input  logic              in_reg_clear_n,
   input  logic [3:0]        in_regfile_location,
   input  logic [3:0]        in_alu_opcode,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic              in_mdr_select,
   input  logic              in_inc_pc,
   input  logic              in_regfile_read,
   input  logic              in_hi_read,
   input  logic              in_lo_read,
   input  logic              in_z_hi_read,
   input  logic              in_z_lo_read,
   input  logic              in_pc_read,
   input  logic              in_mdr_read,
   input  logic              in_inport_read,
   input  logic              in_c_read,
   input  logic              in_regfile_write,
   input  logic              in_hi_write,
   input  logic              in_lo_write,
   input  logic              in_z_write,
   input  logic              in_pc_write,
   input  logic              in_mdr_write,
   input  logic              in_ir_write,
   input  logic              in_y_write,
   input  logic              in_mar_write,
   output logic [DATA_W-1:0] out_bus
);
   logic [DATA_W-1:0]   gpr [NUM_REGS];
   logic [DATA_W-1:0]   pc, ir, y, mar, hi, lo, mdr, bus, pc_inc;
   logic [2*DATA_W-1:0] z, alu_res;
   logic [NUM_SRC-1:0]  rd;
   logic                cy;
   assign rd = {in_c_read, in_inport_read, in_mdr_read, in_pc_read, in_z_lo_read,
                in_z_hi_read, in_lo_read, in_hi_read, in_regfile_read};
   // inport and c are reserved and drive 0; a non-one-hot strobe set also yields 0
   always_comb begin
      bus = !$onehot(rd)      ? '0 :
            rd[SRC_REGFILE]   ? gpr[in_regfile_location] :
            rd[SRC_HI]        ? hi :
            rd[SRC_LO]        ? lo :
            rd[SRC_Z_HI]      ? z[2*DATA_W-1:DATA_W] :
            rd[SRC_Z_LO]      ? z[DATA_W-1:0] :
            rd[SRC_PC]        ? pc :
            rd[SRC_MDR]       ? mdr : '0;
   end
   assign out_bus = bus;
   // dedicated ripple incrementer so PC+1 never competes with the ALU
   always_comb begin
      pc_inc = '0;
      cy = 1'b1;
      for (int k = 0; k < DATA_W; k++) begin
         pc_inc[k] = pc[k] ^ cy;
         cy = pc[k] & cy;
      end
   end
   src_alu_32 u_alu (
      .opcode (in_alu_opcode),
      .a      (y),
      .b      (bus),
      .result (alu_res)
   );
   always_ff @(posedge clk or negedge in_reg_clear_n) begin
      if (!in_reg_clear_n) begin
         for (int k = 0; k < NUM_REGS; k++) gpr[k] <= '0;
         pc  <= '0;
         ir  <= '0;
         y   <= '0;
         z   <= '0;
         mar <= '0;
         hi  <= '0;
         lo  <= '0;
         mdr <= '0;
      end else begin
         if (in_regfile_write) gpr[in_regfile_location] <= bus;
         if (in_pc_write)      pc  <= in_inc_pc ? pc_inc : bus;
         if (in_ir_write)      ir  <= bus;
         if (in_y_write)       y   <= bus;
         if (in_z_write)       z   <= alu_res;
         if (in_mar_write)     mar <= bus;
         if (in_hi_write)      hi  <= bus;
         if (in_lo_write)      lo  <= bus;
         if (in_mdr_write)     mdr <= in_mdr_select ? in_mem_data : bus;
      end
   end
endmodule

// File: tb/tb_src_datapath_32.sv
// tb_src_datapath_32: self-checking bench for the Mini-SRC datapath
module tb_src_datapath_32;
   import src_pkg::*;
   localparam int W_RF = 0, W_HI = 1, W_LO = 2, W_Z = 3, W_PC = 4, W_MDR = 5, W_IR = 6, W_Y = 7, W_MAR = 8;
   logic        clk;
   logic        in_reg_clear_n;
   logic [3:0]  in_regfile_location, in_alu_opcode;
   logic [31:0] in_mem_data, out_bus;
   logic        in_mdr_select, in_inc_pc;
   logic [8:0]  rd_s, wr_s;
   logic [31:0] gpr_m [16];
   int          checks = 0, errors = 0;

   src_datapath_32 dut (
      .clk                 (clk),
      .in_reg_clear_n      (in_reg_clear_n),
      .in_regfile_location (in_regfile_location),
      .in_alu_opcode       (in_alu_opcode),
      .in_mem_data         (in_mem_data),
      .in_mdr_select       (in_mdr_select),
      .in_inc_pc           (in_inc_pc),
      .in_regfile_read     (rd_s[SRC_REGFILE]),
      .in_hi_read          (rd_s[SRC_HI]),
      .in_lo_read          (rd_s[SRC_LO]),
      .in_z_hi_read        (rd_s[SRC_Z_HI]),
      .in_z_lo_read        (rd_s[SRC_Z_LO]),
      .in_pc_read          (rd_s[SRC_PC]),
      .in_mdr_read         (rd_s[SRC_MDR]),
      .in_inport_read      (rd_s[SRC_INPORT]),
      .in_c_read           (rd_s[SRC_C]),
      .in_regfile_write    (wr_s[W_RF]),
      .in_hi_write         (wr_s[W_HI]),
      .in_lo_write         (wr_s[W_LO]),
      .in_z_write          (wr_s[W_Z]),
      .in_pc_write         (wr_s[W_PC]),
      .in_mdr_write        (wr_s[W_MDR]),
      .in_ir_write         (wr_s[W_IR]),
      .in_y_write          (wr_s[W_Y]),
      .in_mar_write        (wr_s[W_MAR]),
      .out_bus             (out_bus)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // behavioural ALU: arithmetic on wide integers straight from the operation definitions
   function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned p, m;
      longint          sa, sb;
      logic [63:0]     r;
      m = 64'h1_0000_0000;
      p = 1;
      for (int k = 0; k < int'(b[4:0]); k++) p = p * 2;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      r = 0;
      case (op)
         4'd0:  r = (a + b) % m;
         4'd1:  r = (m + a - b) % m;
         4'd2:  r = a / p;
         4'd3:  r = (a * p) % m;
         4'd4:  r = a / p + (a % p) * (m / p);
         4'd5:  r = (a * p) % m + a / (m / p);
         4'd6:  r = {32'h0, a & b};
         4'd7:  r = {32'h0, a | b};
         4'd8:  r = sa * sb;
         4'd9:  r = (sb == 0) ? 64'h0 : {32'(sa % sb), 32'(sa / sb)};
         4'd10: r = (m - b) % m;
         4'd11: r = (m - 1) - b;
         default: r = 0;
      endcase
      return r;
   endfunction

   task automatic clr();
      rd_s = '0;
      wr_s = '0;
      in_inc_pc = 0;
      in_mdr_select = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clr();
   endtask

   task automatic peek_mask(input logic [8:0] m, output logic [31:0] v);
      rd_s = m;
      @(negedge clk);
      v = out_bus;
      rd_s = '0;
   endtask

   task automatic peek(input int src, output logic [31:0] v);
      peek_mask(9'(1) << src, v);
   endtask

   task automatic mem_to_mdr(input logic [31:0] v);
      in_mem_data = v;
      in_mdr_select = 1;
      wr_s[W_MDR] = 1;
      tick();
   endtask

   task automatic put(input logic [31:0] v, input int w);
      mem_to_mdr(v);
      rd_s[SRC_MDR] = 1;
      wr_s[w] = 1;
      tick();
   endtask

   task automatic load_reg(input int r, input logic [31:0] v);
      in_regfile_location = 4'(r);
      put(v, W_RF);
      gpr_m[r] = v;
   endtask

   task automatic run_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output logic [63:0] zv);
      logic [31:0] h, l;
      put(a, W_Y);
      mem_to_mdr(b);
      rd_s[SRC_MDR] = 1;
      in_alu_opcode = op;
      wr_s[W_Z] = 1;
      tick();
      peek(SRC_Z_HI, h);
      peek(SRC_Z_LO, l);
      zv = {h, l};
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0] v;
      int srcs[6] = '{SRC_PC, SRC_HI, SRC_LO, SRC_Z_HI, SRC_Z_LO, SRC_MDR};
      foreach (srcs[i]) begin
         peek(srcs[i], v);
         checks++;
         if (v !== 32'h0) begin errors++; $display("FAIL %s src%0d: got %h expected 0", tag, srcs[i], v); end
      end
      for (int r = 0; r < 16; r++) begin
         in_regfile_location = 4'(r);
         peek(SRC_REGFILE, v);
         checks++;
         if (v !== 32'h0) begin errors++; $display("FAIL %s R%0d: got %h expected 0", tag, r, v); end
         gpr_m[r] = 0;
      end
      checks++;
      if ({dut.ir, dut.mar, dut.y} !== 96'h0) begin
         errors++; $display("FAIL %s ir/mar/y: got %h %h %h expected 0", tag, dut.ir, dut.mar, dut.y);
      end
   endtask

   task automatic test_reset();
      clr();
      in_reg_clear_n = 0;
      in_regfile_location = 0;
      in_alu_opcode = 0;
      in_mem_data = 0;
      #12;
      in_reg_clear_n = 1;
      check_all_zero("reset");
   endtask

   task automatic test_and_flow();
      logic [31:0] v;
      load_reg(2, 32'h22);
      load_reg(4, 32'h24);
      load_reg(5, 32'h24);
      in_regfile_location = 2; rd_s[SRC_REGFILE] = 1; wr_s[W_Y] = 1; tick();
      in_regfile_location = 4; rd_s[SRC_REGFILE] = 1; in_alu_opcode = ALU_AND; wr_s[W_Z] = 1; tick();
      in_regfile_location = 5; rd_s[SRC_Z_LO] = 1; wr_s[W_RF] = 1; tick();
      gpr_m[5] = 32'h20;
      peek(SRC_REGFILE, v);
      checks++;
      if (v !== 32'h20) begin errors++; $display("FAIL and_r5: got %h expected 00000020", v); end
      peek(SRC_Z_HI, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL and_zhi: got %h expected 0", v); end
   endtask

   task automatic test_fetch();
      logic [31:0] v;
      rd_s[SRC_PC] = 1; wr_s[W_MAR] = 1; in_inc_pc = 1; wr_s[W_PC] = 1; tick();
      checks++;
      if (dut.mar !== 32'h0) begin errors++; $display("FAIL fetch_mar: got %h expected 0", dut.mar); end
      peek(SRC_PC, v);
      checks++;
      if (v !== 32'h1) begin errors++; $display("FAIL fetch_pc: got %h expected 1", v); end
      put(32'h4A920000, W_IR);
      checks++;
      if (dut.ir !== 32'h4A920000) begin errors++; $display("FAIL fetch_ir: got %h expected 4a920000", dut.ir); end
   endtask

   task automatic test_muldiv();
      logic [63:0] zv;
      run_alu(ALU_MUL, 32'hFFFFFFFE, 32'd3, zv);
      checks++;
      if (zv !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL mul: got %h expected fffffffffffffffa", zv); end
      run_alu(ALU_DIV, 32'd7, 32'd2, zv);
      checks++;
      if (zv !== 64'h00000001_00000003) begin errors++; $display("FAIL div: got %h expected 0000000100000003", zv); end
      run_alu(ALU_DIV, 32'd7, 32'd0, zv);
      checks++;
      if (zv !== 64'h0) begin errors++; $display("FAIL div0: got %h expected 0", zv); end
   endtask

   task automatic test_shifts();
      logic [63:0] zv;
      logic [3:0]  ops[4] = '{ALU_SHR, ALU_SHL, ALU_ROR, ALU_ROL};
      logic [31:0] exp[4] = '{32'h40000000, 32'h00000002, 32'hC0000000, 32'h00000003};
      foreach (ops[i]) begin
         run_alu(ops[i], 32'h80000001, 32'd1, zv);
         checks++;
         if (zv !== {32'h0, exp[i]}) begin errors++; $display("FAIL shift op%0d: got %h expected %h", ops[i], zv, exp[i]); end
      end
   endtask

   task automatic test_bus_default();
      logic [31:0] v;
      logic [8:0]  masks[5] = '{9'h000, 9'h040, 9'h060, 9'h080, 9'h100};
      logic [31:0] exp[5]   = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0};
      mem_to_mdr(32'hA5A5A5A5);
      foreach (masks[i]) begin
         peek_mask(masks[i], v);
         checks++;
         if (v !== exp[i]) begin errors++; $display("FAIL bus mask%h: got %h expected %h", masks[i], v, exp[i]); end
      end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] v;
      put(32'hFFFFFFFF, W_PC);
      peek(SRC_PC, v);
      checks++;
      if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL pc_load: got %h expected ffffffff", v); end
      in_inc_pc = 1; wr_s[W_PC] = 1; tick();
      peek(SRC_PC, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h expected 0", v); end
   endtask

   task automatic test_regfile_random();
      logic [31:0] v;
      for (int i = 0; i < 24; i++) load_reg(int'($urandom_range(0, 15)), $urandom);
      for (int r = 0; r < 16; r++) begin
         in_regfile_location = 4'(r);
         peek(SRC_REGFILE, v);
         checks++;
         if (v !== gpr_m[r]) begin errors++; $display("FAIL regfile R%0d: got %h expected %h", r, v, gpr_m[r]); end
      end
   endtask

   task automatic test_alu_random();
      logic [63:0] zv, exp;
      logic [31:0] a, b;
      logic [3:0]  op;
      for (int i = 0; i < 48; i++) begin
         op = 4'($urandom_range(0, 15));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if (op == ALU_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 1;
         exp = alu_ref(op, a, b);
         run_alu(op, a, b, zv);
         checks++;
         if (zv !== exp) begin errors++; $display("FAIL alu op%0d a=%h b=%h: got %h expected %h", op, a, b, zv, exp); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v, h, l;
      h = $urandom;
      l = $urandom;
      put(h, W_HI);
      put(l, W_LO);
      peek(SRC_HI, v);
      checks++;
      if (v !== h) begin errors++; $display("FAIL hi: got %h expected %h", v, h); end
      peek(SRC_LO, v);
      checks++;
      if (v !== l) begin errors++; $display("FAIL lo: got %h expected %h", v, l); end
      // LO drives the bus while both HI and LO load: both capture the old LO
      rd_s[SRC_LO] = 1; wr_s[W_HI] = 1; wr_s[W_LO] = 1; tick();
      peek(SRC_HI, v);
      checks++;
      if (v !== l) begin errors++; $display("FAIL hi_from_lo: got %h expected %h", v, l); end
   endtask

   task automatic test_async_reset();
      logic [63:0] zv;
      put(32'h1234, W_PC);
      put(32'h5678, W_MAR);
      run_alu(ALU_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, zv);
      put($urandom | 32'h1, W_HI);
      @(posedge clk);
      #3;
      rd_s[SRC_MDR] = 1; wr_s[W_PC] = 1; in_inc_pc = 1; wr_s[W_MAR] = 1; wr_s[W_Z] = 1;
      in_reg_clear_n = 0;
      #1;
      checks++;
      if (out_bus !== 32'h0) begin errors++; $display("FAIL arst_bus: got %h expected 0", out_bus); end
      checks++;
      if ({dut.z, dut.pc, dut.mar} !== 128'h0) begin
         errors++; $display("FAIL arst_now: got z=%h pc=%h mar=%h expected 0", dut.z, dut.pc, dut.mar);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({dut.z, dut.pc, dut.mar} !== 128'h0) begin
         errors++; $display("FAIL arst_held: got z=%h pc=%h mar=%h expected 0", dut.z, dut.pc, dut.mar);
      end
      clr();
      @(negedge clk);
      in_reg_clear_n = 1;
      check_all_zero("arst");
   endtask

   initial begin
      test_reset();
      test_and_flow();
      test_fetch();
      test_muldiv();
      test_shifts();
      test_bus_default();
      test_pc_wrap();
      test_regfile_random();
      test_alu_random();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
